// File: rtl/branch_resolver_pkg.sv
// Shared compare-op encodings, RV32I branch funct3 constants and the S1 pipeline record.
// Included by the comparator and by the branch resolver pipeline.
package branch_resolver_pkg;

  localparam int CMP_OP_W = 3;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    cmp_op_e op;
    logic    illegal;
  } dec_t;

  typedef struct packed {
    logic        result;
    logic        illegal;
    logic        pred_taken;
    logic [31:0] target;
    logic [31:0] seq_pc;
  } s1_t;

  // 010 and 011 have no branch meaning; they decode to EQ and are masked by the illegal flag.
  function automatic dec_t decode_funct3(input logic [2:0] f3);
    dec_t d;
    d.op      = CMP_EQ;
    d.illegal = 1'b0;
    case (f3)
      F3_BEQ:  d.op = CMP_EQ;
      F3_BNE:  d.op = CMP_NE;
      F3_BLT:  d.op = CMP_LT;
      F3_BGE:  d.op = CMP_GE;
      F3_BLTU: d.op = CMP_LTU;
      F3_BGEU: d.op = CMP_GEU;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_resolver_cmp_unit.sv
// Combinational 32-bit comparator for the shared compare-op encoding.
// Zero latency, no flow control.
module cmp_unit
  import branch_resolver_pkg::*;
(
  input  cmp_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        result
);

  always_comb begin
    result = 1'b0;
    case (op)
      CMP_EQ:  result = (a == b);
      CMP_NE:  result = (a != b);
      CMP_LT:  result = ($signed(a) < $signed(b));
      CMP_GE:  result = ($signed(a) >= $signed(b));
      CMP_LTU: result = (a < b);
      CMP_GEU: result = (a >= b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Two-stage branch resolver (S1 compare, S2 resolve): 2-cycle latency, one branch per cycle.
// Valid/ready backpressure ripples combinationally from out_ready to in_ready; flush empties both stages.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int RVC   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_redirect,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [31:0]      out_next_pc,
  output logic [CNT_W-1:0] out_mispred_cnt
);

  logic             s1_vld_q, s1_vld_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             out_redirect_q, out_redirect_d;
  logic             out_illegal_q, out_illegal_d;
  logic             out_misaligned_q, out_misaligned_d;
  logic [31:0]      out_next_pc_q, out_next_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dec_t dec;
  logic cmp_res;
  logic s2_adv, s1_adv, in_fire;
  logic taken_s1, mis_s1;

  assign dec = decode_funct3(in_funct3);

  cmp_unit u_cmp (
    .op     (dec.op),
    .a      (in_rs1),
    .b      (in_rs2),
    .result (cmp_res)
  );

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_vld_q | s2_adv;
  assign in_ready = ~flush & s1_adv;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (s1_adv) s1_vld_d = in_fire;
    if (in_fire) begin
      s1_d.result     = cmp_res;
      s1_d.illegal    = dec.illegal;
      s1_d.pred_taken = in_pred_taken;
      s1_d.target     = in_pc + in_imm;
      s1_d.seq_pc     = in_pc + 32'd4;
    end
    if (flush) s1_vld_d = 1'b0;
  end

  assign taken_s1 = s1_q.result & ~s1_q.illegal;
  assign mis_s1   = taken_s1 & ((RVC != 0) ? s1_q.target[0] : |s1_q.target[1:0]);

  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_redirect_d   = out_redirect_q;
    out_illegal_d    = out_illegal_q;
    out_misaligned_d = out_misaligned_q;
    out_next_pc_d    = out_next_pc_q;
    cnt_d            = cnt_q;
    if (s2_adv) begin
      out_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        out_taken_d      = taken_s1;
        out_redirect_d   = taken_s1 ^ s1_q.pred_taken;
        out_illegal_d    = s1_q.illegal;
        out_misaligned_d = mis_s1;
        out_next_pc_d    = taken_s1 ? s1_q.target : s1_q.seq_pc;
      end
    end
    if (flush) out_valid_d = 1'b0;
    // A delivery in the flush cycle still counts: the consumer has already taken it.
    if (out_valid_q && out_ready && out_redirect_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q         <= 1'b0;
      s1_q             <= '0;
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_redirect_q   <= 1'b0;
      out_illegal_q    <= 1'b0;
      out_misaligned_q <= 1'b0;
      out_next_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      s1_vld_q         <= s1_vld_d;
      s1_q             <= s1_d;
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_redirect_q   <= out_redirect_d;
      out_illegal_q    <= out_illegal_d;
      out_misaligned_q <= out_misaligned_d;
      out_next_pc_q    <= out_next_pc_d;
      cnt_q            <= cnt_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_taken       = out_taken_q;
  assign out_redirect    = out_redirect_q;
  assign out_illegal     = out_illegal_q;
  assign out_misaligned  = out_misaligned_q;
  assign out_next_pc     = out_next_pc_q;
  assign out_mispred_cnt = cnt_q;

endmodule
